zigzag_rle: RTL and testbench

ZIGZAG_RLE -- requirements
Module: zigzag_rle

---
 rtl/zigzag_rle.sv | 156 +++++++++++++++
 tb/tb_zigzag_rle.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_rle.sv
// Zigzag reorder and run-length coder for one 8x8 block of 10-bit signed coefficients.
// The block is loaded in raster order, then emitted as DC / (run, level) / ZRL / EOB symbols.
module zigzag_rle (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [9:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_run,
  output logic [9:0] out_level,
  output logic       out_dc,
  output logic       out_eob
);

  typedef enum logic [1:0] {StLoad, StScan, StFlush} state_e;

  localparam int unsigned ZzToRaster [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  state_e     state_q, state_d;
  logic [9:0] mem_q [64];
  logic [5:0] a_q, a_d;
  logic [5:0] last_nz_q, last_nz_d;
  logic [6:0] z_q, z_d;
  logic [3:0] run_q, run_d;
  logic       valid_d, dc_d, eob_d;
  logic [3:0] orun_d;
  logic [9:0] olevel_d;
  logic       wr_en;
  logic [5:0] raster_zz;
  logic [9:0] coef;

  // Inverse of the zigzag table for the address being loaded.
  always_comb begin
    raster_zz = '0;
    for (int i = 0; i < 64; i++) begin
      if (ZzToRaster[i] == {26'b0, a_q}) raster_zz = 6'(i);
    end
  end

  assign coef     = mem_q[6'(ZzToRaster[z_q[5:0]])];
  assign in_ready = (state_q == StLoad);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    last_nz_d = last_nz_q;
    z_d       = z_q;
    run_d     = run_q;
    valid_d   = out_valid;
    dc_d      = out_dc;
    eob_d     = out_eob;
    orun_d    = out_run;
    olevel_d  = out_level;
    wr_en     = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          wr_en = 1'b1;
          a_d   = a_q + 6'd1;
          if (in_data != '0 && raster_zz > last_nz_q) last_nz_d = raster_zz;
          if (a_q == 6'd63) begin
            state_d  = StScan;
            valid_d  = 1'b1;
            dc_d     = 1'b1;
            eob_d    = 1'b0;
            orun_d   = '0;
            olevel_d = mem_q[0];
            z_d      = 7'd1;
            run_d    = '0;
          end
        end
      end
      StScan: begin
        if (!out_valid || out_ready) begin
          valid_d = 1'b0;
          if (z_q[6] || z_q > {1'b0, last_nz_q}) begin
            state_d  = StFlush;
            valid_d  = 1'b1;
            dc_d     = 1'b0;
            eob_d    = 1'b1;
            orun_d   = '0;
            olevel_d = '0;
          end else if (coef != '0) begin
            valid_d  = 1'b1;
            dc_d     = 1'b0;
            eob_d    = 1'b0;
            orun_d   = run_q;
            olevel_d = coef;
            run_d    = '0;
            z_d      = z_q + 7'd1;
          end else if (run_q == 4'd15) begin
            // Sixteenth consecutive zero: emit ZRL.
            valid_d  = 1'b1;
            dc_d     = 1'b0;
            eob_d    = 1'b0;
            orun_d   = 4'd15;
            olevel_d = '0;
            run_d    = '0;
            z_d      = z_q + 7'd1;
          end else begin
            run_d = run_q + 4'd1;
            z_d   = z_q + 7'd1;
          end
        end
      end
      StFlush: begin
        if (out_ready) begin
          state_d   = StLoad;
          valid_d   = 1'b0;
          a_d       = '0;
          last_nz_d = '0;
          z_d       = '0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      a_q       <= '0;
      last_nz_q <= '0;
      z_q       <= '0;
      run_q     <= '0;
      out_valid <= 1'b0;
      out_dc    <= 1'b0;
      out_eob   <= 1'b0;
      out_run   <= '0;
      out_level <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      last_nz_q <= last_nz_d;
      z_q       <= z_d;
      run_q     <= run_d;
      out_valid <= valid_d;
      out_dc    <= dc_d;
      out_eob   <= eob_d;
      out_run   <= orun_d;
      out_level <= olevel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[a_q] <= in_data;
  end

endmodule

// File: tb/tb_zigzag_rle.sv
// Directed bench for zigzag_rle: hand-computed symbol streams, stall stability, reset and
// in_valid-during-scan behaviour, and reconstruction of a random block.
module tb_zigzag_rle;

  typedef logic [9:0] blk_t [64];

  localparam int unsigned Zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_run;
  logic [9:0] out_level;
  logic       out_dc;
  logic       out_eob;

  int errors = 0;
  int checks = 0;
  bit rand_ready = 1'b0;
  logic [15:0] got [$];
  logic [15:0] exp_q [$];
  logic [15:0] ref_q [$];
  logic [15:0] prev_sym;
  bit stall_prev = 1'b0;

  zigzag_rle dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_run  (out_run),
    .out_level(out_level),
    .out_dc   (out_dc),
    .out_eob  (out_eob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [15:0] sym(input bit dc, input bit eob, input int run, input int lvl);
    return {dc, eob, 4'(run), 10'(lvl)};
  endfunction

  // Symbol monitor: records accepted symbols and checks stability while stalled.
  always @(negedge clk) begin
    if (stall_prev && !rst) begin
      checks++;
      assert ({out_dc, out_eob, out_run, out_level} === prev_sym && out_valid === 1'b1)
      else begin
        errors++;
        $error("FAIL stall_stable obs=%h exp=%h", {out_dc, out_eob, out_run, out_level}, prev_sym);
      end
    end
    if (out_valid && out_ready && !rst) got.push_back({out_dc, out_eob, out_run, out_level});
    stall_prev = out_valid && !out_ready && !rst;
    prev_sym   = {out_dc, out_eob, out_run, out_level};
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic send_block(input blk_t b);
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = b[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  function automatic bit have_eob();
    return got.size() > 0 && got[got.size()-1][14];
  endfunction

  task automatic wait_eob(input string tag, input int budget);
    int n = 0;
    while (!have_eob() && n < budget) begin
      step();
      n++;
    end
    check({tag, "_eob_seen"}, {15'b0, have_eob()}, 16'd1);
    step();
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, 16'(got.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_sym%0d", tag, i), (i < got.size()) ? got[i] : 16'hxxxx, exp_q[i]);
    end
  endtask

  initial begin
    blk_t b;
    blk_t rb;
    blk_t recon;
    int pos;
    int bad;

    // Reset state
    do_reset();
    check("rst_in_ready", {15'b0, in_ready}, 16'd1);
    check("rst_out_valid", {15'b0, out_valid}, 16'd0);
    check("rst_out_run", {12'b0, out_run}, 16'd0);
    check("rst_out_level", {6'b0, out_level}, 16'd0);
    check("rst_out_dc", {15'b0, out_dc}, 16'd0);
    check("rst_out_eob", {15'b0, out_eob}, 16'd0);

    // DC only
    b = '{default: '0};
    b[0] = 10'd5;
    got.delete();
    send_block(b);
    wait_eob("dc_only", 70);
    exp_q = '{sym(1, 0, 0, 5), sym(0, 1, 0, 0)};
    compare_stream("dc_only");
    check("ready_after_eob", {15'b0, in_ready}, 16'd1);

    // Only the last coefficient nonzero: three ZRLs then (14,3)
    b = '{default: '0};
    b[63] = 10'd3;
    got.delete();
    send_block(b);
    wait_eob("last63", 70);
    exp_q = '{sym(1, 0, 0, 0), sym(0, 0, 15, 0), sym(0, 0, 15, 0), sym(0, 0, 15, 0),
              sym(0, 0, 14, 3), sym(0, 1, 0, 0)};
    compare_stream("last63");

    // Negative level
    b = '{default: '0};
    b[1] = 10'h3FE;
    b[8] = 10'd7;
    got.delete();
    send_block(b);
    wait_eob("neg", 70);
    exp_q = '{sym(1, 0, 0, 0), sym(0, 0, 0, 10'h3FE), sym(0, 0, 0, 7), sym(0, 1, 0, 0)};
    compare_stream("neg");

    // Random block: stream with random stalls must match the unstalled stream
    rb = '{default: '0};
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 5) == 0) rb[i] = 10'($urandom_range(1, 1023));
    end
    rb[0]  = 10'h200;
    rb[60] = 10'h1FF;
    got.delete();
    send_block(rb);
    wait_eob("rand_ref", 80);
    ref_q = got;
    got.delete();
    rand_ready = 1'b1;
    send_block(rb);
    wait_eob("rand_stall", 400);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    step();
    exp_q = ref_q;
    compare_stream("rand_stall");
    recon = '{default: '0};
    pos = 0;
    foreach (got[i]) begin
      if (got[i][14]) break;
      if (got[i][15]) begin
        recon[0] = got[i][9:0];
        pos = 1;
      end else if (got[i][13:10] == 4'd15 && got[i][9:0] == '0) begin
        pos += 16;
      end else begin
        pos += int'(got[i][13:10]);
        if (pos < 64) recon[Zz[pos]] = got[i][9:0];
        pos++;
      end
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (recon[i] !== rb[i]) bad++;
    check("rand_recon_bad", 16'(bad), 16'd0);

    // Reset mid-load discards the partial block
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = 10'd7;
      step();
    end
    do_reset();
    b = '{default: '0};
    b[0] = 10'd5;
    send_block(b);
    wait_eob("midrst", 70);
    exp_q = '{sym(1, 0, 0, 5), sym(0, 1, 0, 0)};
    compare_stream("midrst");

    // in_valid held high during SCAN/FLUSH must not write
    b = '{default: '0};
    b[1] = 10'h3FE;
    b[8] = 10'd7;
    got.delete();
    send_block(b);
    rand_ready = 1'b1;
    for (int n = 0; n < 300 && !have_eob(); n++) begin
      in_valid = 1'b1;
      in_data  = 10'd9;
      step();
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    check("hold_eob_seen", {15'b0, have_eob()}, 16'd1);
    exp_q = '{sym(1, 0, 0, 0), sym(0, 0, 0, 10'h3FE), sym(0, 0, 0, 7), sym(0, 1, 0, 0)};
    compare_stream("hold");
    step();
    b = '{default: '0};
    b[0] = 10'd5;
    b[2] = 10'h3F0;
    got.delete();
    send_block(b);
    wait_eob("after_hold", 70);
    exp_q = '{sym(1, 0, 0, 5), sym(0, 0, 4, 10'h3F0), sym(0, 1, 0, 0)};
    compare_stream("after_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
